// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM state enum, the NOP encoding and PC defaults.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        KILL  = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats write, and a write with no usable
// fetched word (miss or stale fetch) loads a bubble instead of garbage.
module if_id_reg
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write,
    input  logic        fill_ok,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        // A bubble keeps the old PC; only ID_Valid and ID_Instr are meaningful.
        if (flush || (write && !fill_ok)) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (write) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc    = pc_q;
    assign id_instr = instr_q;
    assign id_valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, L1 I-cache request FSM and IF/ID load.
// Define IF_FETCH_PERF_EN to add the perf_fetch_cnt / perf_miss_cyc counters.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PCWrite,
    input  logic                IF_Write,
    input  logic                IF_Flush,
    input  logic                Redirect,
    input  logic [bit_size-1:0] Redirect_PC,
    output logic                ic_req,
    output logic [bit_size-1:0] ic_addr,
    input  logic                ic_ready,
    input  logic [bit_size-1:0] ic_rdata,
    output logic [bit_size-1:0] ID_PC,
    output logic [bit_size-1:0] ID_Instr,
    output logic                ID_Valid,
    output logic                IC_Busy,
    output if_state_e           dbg_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_miss_cyc
`endif
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] redir_tgt;
    logic        fill_ok;

    assign redir_tgt = Redirect_PC & ~32'd3;
    // A word returned while in KILL belongs to the stale PC and is dropped.
    assign fill_ok   = ic_ready && (state_q != KILL);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            FETCH, MISS: begin
                if (ic_ready) begin
                    state_d = FETCH;
                    if (Redirect)     pc_d = redir_tgt;
                    else if (PCWrite) pc_d = pc_q + PC_INC;
                end else if (Redirect) begin
                    pend_d  = redir_tgt;
                    state_d = KILL;
                end else begin
                    state_d = MISS;
                end
            end
            KILL: begin
                if (Redirect) pend_d = redir_tgt;
                if (ic_ready) begin
                    pc_d    = Redirect ? redir_tgt : pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC & ~32'd3;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // The PC stays put in KILL, so ic_addr naturally holds the stale address.
    assign ic_req    = ~rst;
    assign ic_addr   = pc_q;
    assign IC_Busy   = ic_req & ~ic_ready;
    assign dbg_state = state_q;

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (IF_Flush),
        .write    (IF_Write),
        .fill_ok  (fill_ok),
        .pc_in    (pc_q),
        .instr_in (ic_rdata),
        .id_pc    (ID_PC),
        .id_instr (ID_Instr),
        .id_valid (ID_Valid)
    );

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] miss_cyc_q, miss_cyc_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        miss_cyc_d  = miss_cyc_q;
        if (!IF_Flush && IF_Write && fill_ok) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (IC_Busy)                          miss_cyc_d  = miss_cyc_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            miss_cyc_q  <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            miss_cyc_q  <= miss_cyc_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_miss_cyc  = miss_cyc_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch front end of the pipelined CPU. It owns the PC register, issues requests to the L1 instruction cache, and loads the IF/ID pipeline register that feeds decode and the hazard detection unit. It obeys the hazard unit's PCWrite / IF_Write / IF_Flush controls and EX-stage redirects. It absorbs L1 miss latency internally by inserting bubbles rather than freezing the back end.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- bit_size, 32, datapath width; only 32 is supported.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  hazard unit; 0 holds the PC.
- IF_Write  in  1  hazard unit; 0 holds IF/ID.
- IF_Flush  in  1  hazard unit; 1 loads a bubble into IF/ID.
- Redirect  in  1  EX stage: taken jump or branch.
- Redirect_PC  in  32  redirect target; bits [1:0] ignored, treated as 00.
- ic_req  out  1  cache request.
- ic_addr  out  32  cache word address, word aligned.
- ic_ready  in  1  cache response valid this cycle; combinational on a hit.
- ic_rdata  in  32  instruction word; valid only while ic_ready=1.
- ID_PC  out  32  PC of the instruction held in IF/ID.
- ID_Instr  out  32  instruction held in IF/ID; 32'h0 (NOP) for a bubble.
- ID_Valid  out  1  IF/ID holds a real instruction.
- IC_Busy  out  1  miss or kill in progress (ic_req=1, ic_ready=0).

## Operation
- The FSM has three states:
  - FETCH: normal operation.
  - MISS: waiting on the cache for the current PC.
  - KILL: waiting on the cache for a fetch that a redirect has made stale.
- Cache handshake:
  - While the FSM is in any state and not in reset, ic_req=1.
  - ic_addr must stay stable until ic_ready=1; an outstanding request is never aborted.
  - ic_addr = PC in FETCH and MISS; in KILL it holds the stale PC.
- In FETCH or MISS, when ic_ready=1:
  - If Redirect=1: PC <= Redirect_PC.
  - Else if PCWrite=1: PC <= PC+4. PC+4 is 32-bit modulo and wraps at 32'hFFFF_FFFC.
  - IF/ID update: if IF_Flush=1, load a bubble. Else if IF_Write=1, load {ID_PC<=PC, ID_Instr<=ic_rdata, ID_Valid<=1}. Else hold.
  - Next state is FETCH.
- In FETCH or MISS, when ic_ready=0:
  - If Redirect=1: pend_pc <= Redirect_PC, go to KILL.
  - Else go to (or stay in) MISS.
  - IF/ID loads a bubble if IF_Flush=1 or IF_Write=1; otherwise it holds. The PC is unchanged.
- In KILL:
  - IF/ID loads a bubble if IF_Flush=1 or IF_Write=1; otherwise it holds.
  - A new Redirect overwrites pend_pc.
  - When ic_ready=1: discard ic_rdata, PC <= pend_pc (or Redirect_PC if Redirect=1 that cycle), go to FETCH.
- Priority: Redirect > PCWrite for the PC; IF_Flush > IF_Write for IF/ID.
- A stall (PCWrite=0, IF_Write=0) on a hit re-requests the same PC next cycle. This is legal and idempotent.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, ic_req=0, ID_PC=0, ID_Instr=0, ID_Valid=0, IC_Busy=0, pend_pc=0.
- First request is issued in the first cycle after rst deasserts.
- Hit latency: the instruction appears in IF/ID one edge after the request cycle. Sustained throughput is one instruction per cycle.
- Miss of N cycles (ic_ready low for N cycles) inserts N bubbles.
- A redirect during a miss costs the remaining miss cycles plus one hit cycle before the target is fetched.
- IC_Busy = ic_req & ~ic_ready (combinational).
- Reset asserted mid-miss returns the block to its reset values immediately. A late ic_ready after reset is ignored because it arrives while the FSM is back in FETCH with ic_req=0 during reset.

## Configuration
- IF_FETCH_PERF_EN:
  - Defined: adds outputs perf_fetch_cnt[31:0] and perf_miss_cyc[31:0].
    - perf_fetch_cnt increments on each IF/ID load with ID_Valid<=1.
    - perf_miss_cyc increments on each cycle with IC_Busy=1.
    - Both counters reset to 0 and wrap at 2^32.
  - Undefined: the ports and counters are absent; functional behaviour is identical.

## Structure
- Shared package if_pkg holds:
  - the FSM state enum (FETCH, MISS, KILL);
  - the NOP constant 32'h0;
  - the default RESET_PC;
  - the PC increment constant 4.
- One sub-module, if_id_reg: holds the IF/ID register and applies the flush/write priority. The FSM and PC logic stay in the top.

## Test plan
- Reset release with RESET_PC=0 and the cache always hitting -> ic_addr steps 0, 4, 8; ID_PC trails by one cycle; ID_Valid=1 from the second cycle.
- Miss at PC=0x40 with ic_ready low for 3 cycles -> 3 bubbles (ID_Valid=0, ID_Instr=0) and IC_Busy=1 for 3 cycles; then ID_PC=0x40.
- Redirect to 0x100 during a miss at 0x40 -> ic_addr held at 0x40 until ready; that word is discarded; next fetch is 0x100; 0x40 never reaches IF/ID.
- Hazard stall: PCWrite=0 and IF_Write=0 for 2 cycles at PC=0x20 -> PC and IF/ID hold; ic_addr=0x20 is repeated; flow resumes with no lost or duplicated instruction.
- Redirect with IF_Flush=1 on a hit at 0x80, target 0x200 -> IF/ID gets a bubble; next ic_addr=0x200.
- With IF_FETCH_PERF_EN defined: 10 hits followed by a 4-cycle miss -> perf_fetch_cnt=10 and perf_miss_cyc=4 before the missed word lands.
